gen_arb_mux: RTL and testbench
==============================

# gen_arb_mux

Parameterised N-channel, packet-locked, registered stream multiplexer. It generalises the plain 2:1 select mux to NCH valid/ready input streams. Channels are chosen by round-robin or fixed-priority arbitration, and a grant is held for a whole packet. Used in the XSPI AXI slave wherever several request/data sources share one downstream path (read-data return, command queue feed), with one output register stage to cut the timing path.

## Interface
Parameters:
- WIDTH, 32, data width per channel
- NCH, 4, number of input channels (≥1)
- SELW, 2, width of channel index; must equal max(1, ceil(log2(NCH)))
- MODE, 0, arbitration: 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  NCH  per-channel beat valid
- in_data  input  NCH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- in_last  input  NCH  per-channel last beat of packet
- in_ready  output  NCH  per-channel beat accepted when in_valid[c] && in_ready[c]
- out_valid  output  1  registered output beat valid
- out_data  output  WIDTH  registered output data
- out_last  output  1  registered last flag
- out_ch  output  SELW  index of the channel that produced the current output beat
- out_ready  input  1  downstream accept

## Operation
- State machine: ARB, LOCK.
- ARB:
  - All in_ready = 0.
  - If any in_valid is set, the winner goes into grant (SELW reg) and the state moves to LOCK next cycle.
  - If no in_valid is set, the block stays in ARB.
- Round-robin (MODE=0): search starts at rr_ptr and wraps at NCH-1 → 0. After a packet's last beat is accepted from channel g, rr_ptr = (g+1) mod NCH.
- Fixed priority (MODE=1): lowest-index valid channel wins; rr_ptr is unused.
- LOCK:
  - in_ready[grant] = (!out_valid || out_ready); all other in_ready = 0.
  - On acceptance: out_data, out_last and out_ch load in_data[grant], in_last[grant] and grant; out_valid = 1.
  - If the accepted beat has in_last = 1, the state returns to ARB.
- Output register:
  - If out_valid && out_ready and no new beat is accepted that cycle, out_valid → 0.
  - While out_valid && !out_ready, out_data, out_last and out_ch must not change.
- If in_valid[grant] drops mid-packet, the grant is held (LOCK persists); no other channel can interrupt.
- in_ready is combinational from state, grant, out_valid and out_ready only. It never depends on in_valid.
- NCH=1: grant is always 0; behaviour is otherwise identical.
- Reset values:
  - state = ARB, grant = 0, rr_ptr = 0
  - out_valid = 0, out_data = 0, out_last = 0, out_ch = 0
  - in_ready = 0
- Reset mid-packet: any partial packet and the held output beat are discarded. There is no flush and no error flag.

## Timing
- Beat latency: accepted at edge t → out_valid high after edge t, visible in cycle t+1.
- Throughput inside a packet: 1 beat/cycle while out_ready = 1.
- Packet turnaround:
  - Last beat accepted in cycle t → ARB in t+1 → LOCK in t+2.
  - The next packet's first beat is accepted no earlier than t+2, so there is exactly one idle input cycle between packets.
- Backpressure: with out_valid = 1 and out_ready = 0, in_ready[grant] = 0 in that same cycle.
- Simultaneous output drain and input accept in one cycle: the register reloads and out_valid stays 1. This gives no bubble.
- The first packet after reset can be accepted in the second cycle with rst = 0. Cycle 1 arbitrates; cycle 2 is LOCK.

## Test plan
- Single channel: NCH=4, only ch2 sends 3 beats (0xA0, 0xA1, 0xA2 with last), out_ready = 1 → out_data A0/A1/A2 on consecutive cycles, out_ch = 2, out_last only on A2, first output one cycle after the first accept.
- Round-robin fairness: MODE=0, all 4 channels continuously sending 1-beat packets → out_ch sequence 0,1,2,3,0,1,…, each packet separated by exactly one idle output cycle.
- Fixed priority: MODE=1, ch0 and ch3 both always valid → out_ch always 0 and ch3 starves; drop ch0 → ch3 is granted on the next ARB.
- Packet lock and backpressure: ch1 sends a 4-beat packet, ch0 is valid throughout, out_ready toggles 1,0,0,1,… → all 4 ch1 beats are output in order with no ch0 beat interleaved, and data stays stable while out_ready = 0.
- Mid-packet gap: ch1 drops in_valid for 3 cycles after beat 2 of 4 → grant is held, the remaining beats follow, and no other channel's beat appears before ch1's last.
- Reset mid-packet: assert rst for 1 cycle during beat 2 of a ch2 packet → next cycle out_valid = 0, out_ch = 0, in_ready = 0, rr_ptr = 0; a subsequent request from ch0 and ch2 is granted to ch0 first.

Source files
------------

// File: rtl/gen_arb_mux.sv
// gen_arb_mux: N-channel packet-locked registered stream mux
// Round-robin or fixed-priority grant held for a whole packet.
module gen_arb_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_last,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  grant_nxt;
  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  rr_ptr_nxt;
  logic [SELW-1:0]  winner;
  logic             any_valid;
  logic             acc_en;
  logic             accept;
  logic             sel_valid;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;

  assign any_valid = |in_valid;

  // The output slot is free when empty or being drained this cycle.
  assign acc_en = (state == LOCK) && (!out_valid || out_ready);

  assign accept = acc_en && sel_valid;

  // Pick the valid channel closest (cyclically) to the search start.
  always_comb begin : find_winner
    int start;
    int d;
    int best_d;
    winner = '0;
    best_d = NCH;
    start  = (MODE == 0) ? int'(rr_ptr) : 0;
    for (int c = 0; c < NCH; c++) begin
      d = c - start;
      if (d < 0) d = d + NCH;
      if (in_valid[c] && (d < best_d)) begin
        best_d = d;
        winner = SELW'(c);
      end
    end
  end

  // Route the granted channel's beat to the output register input.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (grant == SELW'(c)) begin
        sel_valid = in_valid[c];
        sel_last  = in_last[c];
        sel_data  = in_data[c*WIDTH +: WIDTH];
      end
    end
  end

  // Only the granted channel may see ready; never a function of in_valid.
  always_comb begin
    in_ready = '0;
    for (int c = 0; c < NCH; c++) begin
      in_ready[c] = acc_en && (grant == SELW'(c));
    end
  end

  // Arbitrate in ARB, hold the grant until the last beat is taken.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    unique case (state)
      ARB: begin
        if (any_valid) begin
          grant_nxt = winner;
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        if (accept && sel_last) begin
          state_nxt = ARB;
          if (MODE == 0) begin
            if (grant == SELW'(NCH - 1))
              rr_ptr_nxt = '0;
            else
              rr_ptr_nxt = grant + 1'b1;
          end
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Output stage: load on accept, clear valid on a drain without reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_ch    <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gen_arb_mux.sv
// tb_gen_arb_mux: directed checks of gen_arb_mux
// Round-robin and fixed-priority instances share one clock.
module tb_gen_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         r_rst;
  logic [3:0]   r_valid;
  logic [127:0] r_data;
  logic [3:0]   r_last;
  logic [3:0]   r_irdy;
  logic         r_ovalid;
  logic [31:0]  r_odata;
  logic         r_olast;
  logic [1:0]   r_och;
  logic         r_ordy;

  logic         f_rst;
  logic [3:0]   f_valid;
  logic [127:0] f_data;
  logic [3:0]   f_last;
  logic [3:0]   f_irdy;
  logic         f_ovalid;
  logic [31:0]  f_odata;
  logic         f_olast;
  logic [1:0]   f_och;
  logic         f_ordy;

  gen_arb_mux #(
    .WIDTH(32), .NCH(4), .SELW(2), .MODE(0)
  ) u_rr (
    .clk(clk), .rst(r_rst),
    .in_valid(r_valid), .in_data(r_data),
    .in_last(r_last), .in_ready(r_irdy),
    .out_valid(r_ovalid), .out_data(r_odata),
    .out_last(r_olast), .out_ch(r_och),
    .out_ready(r_ordy)
  );

  gen_arb_mux #(
    .WIDTH(32), .NCH(4), .SELW(2), .MODE(1)
  ) u_fp (
    .clk(clk), .rst(f_rst),
    .in_valid(f_valid), .in_data(f_data),
    .in_last(f_last), .in_ready(f_irdy),
    .out_valid(f_ovalid), .out_data(f_odata),
    .out_last(f_olast), .out_ch(f_och),
    .out_ready(f_ordy)
  );

  int nchk = 0;
  int nfail = 0;

  int nbeat[4];
  int start[4];
  int gap_ch;
  int gap_after;
  int gap_len;
  int exp_ch[$];
  int exp_bt[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkdata(input int c, input int b);
    return {16'hD000, 8'(c), 8'(b)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives packets per nbeat/start/gap and checks output beats in order.
  task automatic run_pkts(input string tag,
                          input int cyc_max,
                          input bit tog);
    int bi[4];
    int gapc;
    int oi;
    logic [3:0] hs;
    int ec;
    int eb;
    for (int c = 0; c < 4; c++) bi[c] = 0;
    gapc = 0;
    oi = 0;
    for (int cyc = 0; cyc < cyc_max && oi < exp_ch.size(); cyc++) begin
      for (int c = 0; c < 4; c++) begin
        r_valid[c] = (cyc >= start[c]) && (bi[c] < nbeat[c]) &&
                     !(c == gap_ch && bi[c] == gap_after &&
                       gapc < gap_len);
        r_data[c*32 +: 32] = mkdata(c, bi[c]);
        r_last[c] = (bi[c] == nbeat[c] - 1);
      end
      r_ordy = tog ? (cyc % 3 == 0) : 1'b1;
      #1;
      if (r_ovalid) begin
        ec = exp_ch[oi];
        eb = exp_bt[oi];
        chk({tag, "_ch"}, r_och, ec);
        chk({tag, "_data"}, r_odata, mkdata(ec, eb));
        chk({tag, "_last"}, r_olast, (eb == nbeat[ec] - 1));
        if (r_ordy) oi++;
      end
      hs = r_valid & r_irdy;
      if (bi[gap_ch] == gap_after && gapc < gap_len) gapc++;
      step();
      for (int c = 0; c < 4; c++) if (hs[c]) bi[c]++;
    end
    chk({tag, "_count"}, oi, exp_ch.size());
    r_valid = '0;
    r_last = '0;
    r_ordy = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    r_rst = 1'b1; r_valid = '0; r_data = '0;
    r_last = '0; r_ordy = 1'b1;
    f_rst = 1'b1; f_valid = '0; f_data = '0;
    f_last = '0; f_ordy = 1'b1;
    step();
    step();
    r_rst = 1'b0;
    f_rst = 1'b0;
    #1;
    chk("rst_ovalid", r_ovalid, 0);
    chk("rst_odata", r_odata, 0);
    chk("rst_olast", r_olast, 0);
    chk("rst_och", r_och, 0);
    chk("rst_irdy", r_irdy, 0);
    chk("rst_f_ovalid", f_ovalid, 0);
    chk("rst_f_irdy", f_irdy, 0);

    // Single channel, 3 beats on ch2.
    r_valid = 4'b0100;
    r_data[64 +: 32] = 32'hA0;
    r_last = 4'b0000;
    #1;
    chk("t1_arb_irdy", r_irdy, 4'b0000);
    step();
    chk("t1_lock_irdy", r_irdy, 4'b0100);
    chk("t1_lat_ovalid", r_ovalid, 0);
    step();
    r_data[64 +: 32] = 32'hA1;
    chk("t1_b0_valid", r_ovalid, 1);
    chk("t1_b0_data", r_odata, 32'hA0);
    chk("t1_b0_ch", r_och, 2);
    chk("t1_b0_last", r_olast, 0);
    step();
    r_data[64 +: 32] = 32'hA2;
    r_last = 4'b0100;
    chk("t1_b1_data", r_odata, 32'hA1);
    chk("t1_b1_last", r_olast, 0);
    step();
    r_valid = '0;
    r_last = '0;
    #1;
    chk("t1_b2_data", r_odata, 32'hA2);
    chk("t1_b2_last", r_olast, 1);
    chk("t1_b2_ch", r_och, 2);
    chk("t1_b2_irdy", r_irdy, 4'b0000);
    step();
    chk("t1_drain", r_ovalid, 0);

    // Round-robin fairness with 1-beat packets on all channels.
    r_rst = 1'b1;
    step();
    r_rst = 1'b0;
    r_valid = 4'b1111;
    r_last = 4'b1111;
    for (int c = 0; c < 4; c++) r_data[c*32 +: 32] = mkdata(c, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t2_idle", r_ovalid, 0);
      step();
      chk("t2_valid", r_ovalid, 1);
      chk("t2_ch", r_och, k % 4);
      chk("t2_data", r_odata, mkdata(k % 4, 0));
    end
    r_valid = '0;
    r_last = '0;
    step();

    // Fixed priority: ch0 starves ch3 until ch0 drops.
    f_valid = 4'b1001;
    f_last = 4'b1111;
    for (int c = 0; c < 4; c++) f_data[c*32 +: 32] = mkdata(c, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_idle", f_ovalid, 0);
      chk("t3_irdy", f_irdy, 4'b0001);
      step();
      chk("t3_valid", f_ovalid, 1);
      chk("t3_ch", f_och, 0);
    end
    f_valid = 4'b1000;
    step();
    chk("t3_sw_irdy", f_irdy, 4'b1000);
    step();
    chk("t3_sw_valid", f_ovalid, 1);
    chk("t3_sw_ch", f_och, 3);
    chk("t3_sw_data", f_odata, mkdata(3, 0));
    f_valid = '0;

    // Packet lock under backpressure, ch0 waiting.
    r_rst = 1'b1;
    step();
    r_rst = 1'b0;
    nbeat = '{1, 4, 0, 0};
    start = '{1, 0, 0, 0};
    gap_ch = 1; gap_after = 0; gap_len = 0;
    exp_ch = '{1, 1, 1, 1, 0};
    exp_bt = '{0, 1, 2, 3, 0};
    run_pkts("t4", 60, 1'b1);

    // Mid-packet gap on ch1 holds the grant.
    r_rst = 1'b1;
    step();
    r_rst = 1'b0;
    nbeat = '{1, 4, 1, 0};
    start = '{1, 0, 1, 0};
    gap_ch = 1; gap_after = 2; gap_len = 3;
    exp_ch = '{1, 1, 1, 1, 2, 0};
    exp_bt = '{0, 1, 2, 3, 0, 0};
    run_pkts("t5", 60, 1'b0);

    // Reset in the middle of a ch2 packet; rr pointer is 1 here.
    r_valid = 4'b0100;
    r_data[64 +: 32] = mkdata(2, 0);
    r_last = 4'b0000;
    r_ordy = 1'b1;
    step();
    chk("t6_lock_irdy", r_irdy, 4'b0100);
    step();
    r_data[64 +: 32] = mkdata(2, 1);
    chk("t6_b0_data", r_odata, mkdata(2, 0));
    step();
    r_data[64 +: 32] = mkdata(2, 2);
    r_rst = 1'b1;
    step();
    r_rst = 1'b0;
    r_valid = 4'b0101;
    r_data[0 +: 32] = mkdata(0, 0);
    r_data[64 +: 32] = mkdata(2, 0);
    r_last = 4'b0001;
    #1;
    chk("t6_rst_ovalid", r_ovalid, 0);
    chk("t6_rst_och", r_och, 0);
    chk("t6_rst_odata", r_odata, 0);
    chk("t6_rst_irdy", r_irdy, 4'b0000);
    step();
    chk("t6_regrant", r_irdy, 4'b0001);
    step();
    chk("t6_out_valid", r_ovalid, 1);
    chk("t6_out_ch", r_och, 0);
    chk("t6_out_data", r_odata, mkdata(0, 0));
    r_valid = '0;
    r_last = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
